// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and the per-stage next-value select.
package usr_pkg;

  typedef logic [2:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 3'd0;
  localparam usr_mode_t MODE_SHF  = 3'd1;
  localparam usr_mode_t MODE_SHR  = 3'd2;
  localparam usr_mode_t MODE_LOAD = 3'd3;
  localparam usr_mode_t MODE_ROT  = 3'd4;
  localparam usr_mode_t MODE_CLR  = 3'd5;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_LEFT  = 2'd1,
    SEL_RIGHT = 2'd2,
    SEL_PAR   = 2'd3
  } usr_sel_t;

  // Modes that push a new serial sample in and therefore advance the fill level.
  function automatic logic is_shift(input usr_mode_t m);
    return (m == MODE_SHF) || (m == MODE_SHR);
  endfunction

endpackage

// File: rtl/usr_chk.sv
// Simulation checker for univ_shift_reg control inputs; bound to the
// design's ports from the verification environment.
module usr_chk (
  input logic       clk,
  input logic       clear,
  input logic       en,
  input logic [2:0] mode
);

  a_mode_known: assert property (@(posedge clk) disable iff (!clear) en |-> !$isunknown(mode));

endmodule

// File: rtl/usr_stage.sv
// One WIDTH-bit stage of the universal shift register: a 4:1 next-value mux
// with synchronous clear in front of a register with async active-low clear.
module usr_stage
  import usr_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             sclr,
  input  usr_sel_t         sel,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_s;

  // Next-value select; synchronous clear overrides every other source.
  always_comb begin
    d_s = q_r;
    if (sclr) begin
      d_s = '0;
    end else begin
      case (sel)
        SEL_HOLD:  d_s = q_r;
        SEL_LEFT:  d_s = left_in;
        SEL_RIGHT: d_s = right_in;
        SEL_PAR:   d_s = par_in;
        default:   d_s = q_r;
      endcase
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_r <= '0;
    end else if (en) begin
      q_r <= d_s;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, shift either way, parallel
// load, forward rotate and synchronous clear, with a saturating fill count.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   ser_in,
  input  logic [DEPTH*WIDTH-1:0] par_in,
  output logic [DEPTH*WIDTH-1:0] par_out,
  output logic [WIDTH-1:0]   so_fwd,
  output logic [WIDTH-1:0]   so_rev,
  output logic [CW-1:0]      fill_cnt,
  output logic               full
);

  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] stage_s [DEPTH];
  usr_sel_t         sel_s;
  logic             sclr_s;
  logic             rot_s;
  logic [CW-1:0]    fill_nxt_s;
  logic [CW-1:0]    fill_cnt_r;
  logic             full_r;

  // Mode decode into stage controls and next fill level.
  always_comb begin
    sel_s      = SEL_HOLD;
    sclr_s     = 1'b0;
    rot_s      = 1'b0;
    fill_nxt_s = fill_cnt_r;
    case (mode)
      MODE_SHF:  sel_s = SEL_LEFT;
      MODE_SHR:  sel_s = SEL_RIGHT;
      MODE_LOAD: begin
        sel_s      = SEL_PAR;
        fill_nxt_s = FILL_MAX;
      end
      MODE_ROT: begin
        sel_s = SEL_LEFT;
        rot_s = 1'b1;
      end
      MODE_CLR: begin
        sclr_s     = 1'b1;
        fill_nxt_s = '0;
      end
      default: sel_s = SEL_HOLD;
    endcase
    if (is_shift(mode) && (fill_cnt_r != FILL_MAX)) begin
      fill_nxt_s = fill_cnt_r + CW'(1);
    end else begin
      fill_nxt_s = fill_nxt_s;
    end
  end

  // Stage 0 takes ser_in on a shift but wraps the last stage on a rotate.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] left_s;
    logic [WIDTH-1:0] right_s;

    if (i == 0) begin : g_first
      assign left_s = rot_s ? stage_s[DEPTH-1] : ser_in;
    end else begin : g_mid_l
      assign left_s = stage_s[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign right_s = ser_in;
    end else begin : g_mid_r
      assign right_s = stage_s[i+1];
    end

    usr_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .clear    (clear),
      .en       (en),
      .sclr     (sclr_s),
      .sel      (sel_s),
      .left_in  (left_s),
      .right_in (right_s),
      .par_in   (par_in[i*WIDTH +: WIDTH]),
      .q        (stage_s[i])
    );

    assign par_out[i*WIDTH +: WIDTH] = stage_s[i];
  end

  // Fill level and full flag advance together.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      fill_cnt_r <= '0;
      full_r     <= 1'b0;
    end else if (en) begin
      fill_cnt_r <= fill_nxt_s;
      full_r     <= (fill_nxt_s == FILL_MAX);
    end else begin
      fill_cnt_r <= fill_cnt_r;
      full_r     <= full_r;
    end
  end

  assign so_fwd   = stage_s[DEPTH-1];
  assign so_rev   = stage_s[0];
  assign fill_cnt = fill_cnt_r;
  assign full     = full_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg across four parameter sets.
module tb_univ_shift_reg;

  logic        clk = 1'b0;
  logic        clear;
  logic        en;
  logic [2:0]  mode;
  logic        ser1;
  logic [7:0]  ser8;
  logic [3:0]  par1;
  logic [31:0] par8;
  logic [1:0]  par2;
  logic [63:0] par64;

  logic [3:0]  po1;   logic fwd1;  logic rev1;  logic [2:0] fill1;  logic full1;
  logic [31:0] po8;   logic [7:0] fwd8; logic [7:0] rev8; logic [2:0] fill8; logic full8;
  logic [1:0]  po2;   logic fwd2;  logic rev2;  logic [1:0] fill2;  logic full2;
  logic [63:0] po64;  logic fwd64; logic rev64; logic [6:0] fill64; logic full64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(1), .DEPTH(4)) dut1 (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .ser_in(ser1), .par_in(par1),
    .par_out(po1), .so_fwd(fwd1), .so_rev(rev1), .fill_cnt(fill1), .full(full1));

  univ_shift_reg #(.WIDTH(8), .DEPTH(4)) dut8 (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .ser_in(ser8), .par_in(par8),
    .par_out(po8), .so_fwd(fwd8), .so_rev(rev8), .fill_cnt(fill8), .full(full8));

  univ_shift_reg #(.WIDTH(1), .DEPTH(2)) dut2 (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .ser_in(ser1), .par_in(par2),
    .par_out(po2), .so_fwd(fwd2), .so_rev(rev2), .fill_cnt(fill2), .full(full2));

  univ_shift_reg #(.WIDTH(1), .DEPTH(64)) dut64 (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .ser_in(ser1), .par_in(par64),
    .par_out(po64), .so_fwd(fwd64), .so_rev(rev64), .fill_cnt(fill64), .full(full64));

  usr_chk u_chk (.clk(clk), .clear(clear), .en(en), .mode(mode));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++; if (po1 !== 4'h0)          begin bad++; $display("FAIL reset_po1 got %h want 0", po1); end
    total++; if (fill1 !== 3'd0)        begin bad++; $display("FAIL reset_fill1 got %0d want 0", fill1); end
    total++; if (full1 !== 1'b0)        begin bad++; $display("FAIL reset_full1 got %b want 0", full1); end
    total++; if (po8 !== 32'h0)         begin bad++; $display("FAIL reset_po8 got %h want 0", po8); end
    total++; if (po2 !== 2'b00)         begin bad++; $display("FAIL reset_po2 got %b want 0", po2); end
    total++; if (po64 !== 64'h0)        begin bad++; $display("FAIL reset_po64 got %h want 0", po64); end
    total++; if (fill64 !== 7'd0)       begin bad++; $display("FAIL reset_fill64 got %0d want 0", fill64); end
    #3;
    clear = 1'b1;
  endtask

  task automatic test_shf();
    logic [7:0] seq;
    logic [3:0] exp_par [8];
    logic [2:0] exp_fill [8];
    seq      = 8'b1100_1100;
    exp_par  = '{4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};
    exp_fill = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    en   = 1'b1;
    mode = 3'd1;
    for (int k = 0; k < 8; k++) begin
      ser1 = seq[k];
      tick();
      total++; if (po1 !== exp_par[k])    begin bad++; $display("FAIL shf_par edge %0d got %b want %b", k+1, po1, exp_par[k]); end
      total++; if (fwd1 !== exp_par[k][3]) begin bad++; $display("FAIL shf_fwd edge %0d got %b want %b", k+1, fwd1, exp_par[k][3]); end
      total++; if (fill1 !== exp_fill[k]) begin bad++; $display("FAIL shf_fill edge %0d got %0d want %0d", k+1, fill1, exp_fill[k]); end
      total++; if (full1 !== (k >= 3))    begin bad++; $display("FAIL shf_full edge %0d got %b want %b", k+1, full1, (k >= 3)); end
    end
  endtask

  task automatic test_load_rot();
    logic [31:0] exp_rot [4];
    exp_rot = '{32'h33221144, 32'h22114433, 32'h11443322, 32'h44332211};
    par8 = 32'h44332211;
    mode = 3'd3;
    tick();
    total++; if (po8 !== 32'h44332211) begin bad++; $display("FAIL load_po got %h want 44332211", po8); end
    total++; if (fwd8 !== 8'h44)       begin bad++; $display("FAIL load_fwd got %h want 44", fwd8); end
    total++; if (rev8 !== 8'h11)       begin bad++; $display("FAIL load_rev got %h want 11", rev8); end
    total++; if (fill8 !== 3'd4)       begin bad++; $display("FAIL load_fill got %0d want 4", fill8); end
    total++; if (full8 !== 1'b1)       begin bad++; $display("FAIL load_full got %b want 1", full8); end
    mode = 3'd4;
    ser8 = 8'hEE;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (po8 !== exp_rot[k]) begin bad++; $display("FAIL rot_po step %0d got %h want %h", k+1, po8, exp_rot[k]); end
      total++; if (fill8 !== 3'd4)     begin bad++; $display("FAIL rot_fill step %0d got %0d want 4", k+1, fill8); end
    end
  endtask

  task automatic test_back_to_back();
    mode = 3'd2;
    ser8 = 8'hAA;
    tick();
    total++; if (po8 !== 32'hAA443322) begin bad++; $display("FAIL shr_po got %h want aa443322", po8); end
    total++; if (rev8 !== 8'h22)       begin bad++; $display("FAIL shr_rev got %h want 22", rev8); end
    total++; if (fill8 !== 3'd4)       begin bad++; $display("FAIL shr_fill got %0d want 4", fill8); end
    mode = 3'd1;
    ser8 = 8'h55;
    tick();
    total++; if (po8 !== 32'h44332255) begin bad++; $display("FAIL shf_after_shr_po got %h want 44332255", po8); end
    total++; if (fwd8 !== 8'h44)       begin bad++; $display("FAIL shf_after_shr_fwd got %h want 44", fwd8); end
  endtask

  task automatic test_hold();
    logic [2:0] hold_modes [3];
    hold_modes = '{3'd0, 3'd6, 3'd7};
    mode = 3'd5;
    tick();
    total++; if (po8 !== 32'h0)  begin bad++; $display("FAIL clr_po8 got %h want 0", po8); end
    total++; if (fill8 !== 3'd0) begin bad++; $display("FAIL clr_fill8 got %0d want 0", fill8); end
    total++; if (full8 !== 1'b0) begin bad++; $display("FAIL clr_full8 got %b want 0", full8); end
    mode = 3'd1;
    ser8 = 8'h5A;
    ser1 = 1'b1;
    tick();
    total++; if (po8 !== 32'h0000005A) begin bad++; $display("FAIL pre_hold_po8 got %h want 0000005a", po8); end
    total++; if (fill8 !== 3'd1)       begin bad++; $display("FAIL pre_hold_fill8 got %0d want 1", fill8); end
    en   = 1'b0;
    ser8 = 8'hFF;
    ser1 = 1'b0;
    par8 = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (po8 !== 32'h0000005A) begin bad++; $display("FAIL en0_po8 edge %0d got %h want 0000005a", k+1, po8); end
      total++; if (fill8 !== 3'd1)       begin bad++; $display("FAIL en0_fill8 edge %0d got %0d want 1", k+1, fill8); end
      total++; if (po1 !== 4'b0001)      begin bad++; $display("FAIL en0_po1 edge %0d got %b want 0001", k+1, po1); end
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mode = hold_modes[k];
      tick();
      total++; if (po8 !== 32'h0000005A) begin bad++; $display("FAIL hold_po8 mode %0d got %h want 0000005a", hold_modes[k], po8); end
      total++; if (fill8 !== 3'd1)       begin bad++; $display("FAIL hold_fill8 mode %0d got %0d want 1", hold_modes[k], fill8); end
      total++; if (full8 !== 1'b0)       begin bad++; $display("FAIL hold_full8 mode %0d got %b want 0", hold_modes[k], full8); end
    end
  endtask

  task automatic test_async_clear();
    mode = 3'd1;
    ser1 = 1'b1;
    ser8 = 8'h3C;
    tick();
    total++; if (po1 !== 4'b0011)      begin bad++; $display("FAIL pre_clr_po1 got %b want 0011", po1); end
    total++; if (fill1 !== 3'd2)       begin bad++; $display("FAIL pre_clr_fill1 got %0d want 2", fill1); end
    total++; if (po8 !== 32'h00005A3C) begin bad++; $display("FAIL pre_clr_po8 got %h want 00005a3c", po8); end
    #2;
    clear = 1'b0;
    #1;
    total++; if (po1 !== 4'b0000) begin bad++; $display("FAIL aclr_po1 got %b want 0000", po1); end
    total++; if (fill1 !== 3'd0)  begin bad++; $display("FAIL aclr_fill1 got %0d want 0", fill1); end
    total++; if (full1 !== 1'b0)  begin bad++; $display("FAIL aclr_full1 got %b want 0", full1); end
    total++; if (po8 !== 32'h0)   begin bad++; $display("FAIL aclr_po8 got %h want 0", po8); end
    total++; if (fill8 !== 3'd0)  begin bad++; $display("FAIL aclr_fill8 got %0d want 0", fill8); end
    tick();
    total++; if (po1 !== 4'b0000) begin bad++; $display("FAIL aclr_held_po1 got %b want 0000", po1); end
    total++; if (fill1 !== 3'd0)  begin bad++; $display("FAIL aclr_held_fill1 got %0d want 0", fill1); end
    clear = 1'b1;
  endtask

  task automatic test_clr_mode();
    mode = 3'd3;
    par1 = 4'b1011;
    tick();
    total++; if (po1 !== 4'b1011) begin bad++; $display("FAIL load1_po got %b want 1011", po1); end
    total++; if (full1 !== 1'b1)  begin bad++; $display("FAIL load1_full got %b want 1", full1); end
    mode = 3'd5;
    tick();
    total++; if (po1 !== 4'b0000) begin bad++; $display("FAIL clr1_po got %b want 0000", po1); end
    total++; if (fill1 !== 3'd0)  begin bad++; $display("FAIL clr1_fill got %0d want 0", fill1); end
    total++; if (full1 !== 1'b0)  begin bad++; $display("FAIL clr1_full got %b want 0", full1); end
  endtask

  task automatic test_saturate();
    logic [127:0] pat;
    logic [1:0]   exp_fill2;
    logic [6:0]   exp_fill64;
    logic         exp_fwd2;
    logic         exp_fwd64;
    pat  = 128'h0000_0000_0000_002A_5C3F_0E91_B7D4_6183;
    mode = 3'd5;
    tick();
    mode = 3'd1;
    for (int k = 0; k < 70; k++) begin
      ser1 = pat[k];
      tick();
      exp_fill2  = (k >= 1)  ? 2'd2  : 2'(k + 1);
      exp_fill64 = (k >= 63) ? 7'd64 : 7'(k + 1);
      exp_fwd2   = (k >= 1)  ? pat[k-1]  : 1'b0;
      exp_fwd64  = (k >= 63) ? pat[k-63] : 1'b0;
      total++; if (fwd2 !== exp_fwd2)     begin bad++; $display("FAIL sat_fwd2 edge %0d got %b want %b", k+1, fwd2, exp_fwd2); end
      total++; if (fill2 !== exp_fill2)   begin bad++; $display("FAIL sat_fill2 edge %0d got %0d want %0d", k+1, fill2, exp_fill2); end
      total++; if (full2 !== (k >= 1))    begin bad++; $display("FAIL sat_full2 edge %0d got %b want %b", k+1, full2, (k >= 1)); end
      total++; if (fwd64 !== exp_fwd64)   begin bad++; $display("FAIL sat_fwd64 edge %0d got %b want %b", k+1, fwd64, exp_fwd64); end
      total++; if (fill64 !== exp_fill64) begin bad++; $display("FAIL sat_fill64 edge %0d got %0d want %0d", k+1, fill64, exp_fill64); end
      total++; if (full64 !== (k >= 63))  begin bad++; $display("FAIL sat_full64 edge %0d got %b want %b", k+1, full64, (k >= 63)); end
    end
  endtask

  initial begin
    clear = 1'b1;
    en    = 1'b0;
    mode  = 3'd0;
    ser1  = 1'b0;
    ser8  = 8'h00;
    par1  = 4'h0;
    par8  = 32'h0;
    par2  = 2'b00;
    par64 = 64'h0;
    #1;
    clear = 1'b0;
    test_reset();
    test_shf();
    test_load_rot();
    test_back_to_back();
    test_hold();
    test_async_clear();
    test_clr_mode();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
